bmem_resp: RTL and testbench
============================

BMEM_RESP -- requirements
Module: bmem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from read acceptance to first data beat when idle (legal range 2..15).
REQ-002 SHALL have parameter QDEPTH, default 4, meaning number of outstanding read requests held.
REQ-003 SHALL have parameter IDX_W, default 6, meaning log2 of the number of 32-byte lines stored.
REQ-004 SHALL have one clock and a synchronous, active-low reset: port clk, input, 1 bit, the only clock; port rst, input, 1 bit, synchronous active-low reset.
REQ-005 SHALL have port bmem_addr, input, 32 bits, request line address.
REQ-006 SHALL have port bmem_read, input, 1 bit, read request.
REQ-007 SHALL have port bmem_write, input, 1 bit, write beat valid.
REQ-008 SHALL have port bmem_wdata, input, 64 bits, write beat data.
REQ-009 SHALL have port bmem_ready, output, 1 bit, request/beat accepted when high.
REQ-010 SHALL have port bmem_raddr, output, 32 bits, line address of the returning burst.
REQ-011 SHALL have port bmem_rdata, output, 64 bits, read beat data.
REQ-012 SHALL have port bmem_rvalid, output, 1 bit, read beat valid.

Function
REQ-013 SHALL store 2^IDX_W lines of 256 bits, indexed by bmem_addr[5+IDX_W-1:5]; bits [4:0] ignored; upper bits ignored (aliasing).
REQ-014 SHALL accept a read when bmem_read && bmem_ready at a rising edge, enqueueing the line address into an in-order FIFO of QDEPTH entries.
REQ-015 SHALL treat a write as 4 consecutive beats with bmem_write high and bmem_addr held; beat k (0..3) writes line bits [64k+63:64k] at the edge it is accepted.
REQ-016 SHALL drive bmem_ready = !full outside a write burst, and 1 during write beats 1..3 (a started write burst is never stalled).
REQ-017 SHALL ignore bmem_read during write beats 1..3; simultaneous bmem_read and bmem_write outside a burst is a protocol error (no defined behaviour).
REQ-018 SHALL keep a per-entry age counter, incremented each cycle and saturating at LATENCY.
REQ-019 SHALL run a response FSM with states IDLE, WAIT, BURST: IDLE->WAIT when FIFO non-empty; WAIT->BURST when head age reaches LATENCY; BURST holds 4 cycles, then ->WAIT if another entry is queued, else ->IDLE.
REQ-020 SHALL, when idle, present the first beat in cycle T+LATENCY for a read accepted in cycle T.
REQ-021 SHALL start a queued burst in the cycle immediately after the previous last beat if its age has reached LATENCY (no bubble).
REQ-022 SHALL, in BURST beat k, drive bmem_rvalid=1, bmem_rdata = line bits [64k+63:64k], and bmem_raddr = head address with [4:0]=0; all three SHALL be 0 outside BURST.
REQ-023 SHALL read line contents at beat time, so write beats completed before a read beat are visible to that beat.
REQ-024 SHALL dequeue the head on its 4th beat; a full FIFO keeps bmem_ready=0 in that cycle (no same-cycle bypass), and ready rises the next cycle.
REQ-025 SHALL allow enqueue and dequeue in the same cycle when not full, leaving the count unchanged.
REQ-026 SHALL hold the FIFO count in 0..QDEPTH, with pointers wrapping modulo QDEPTH.

Reset
REQ-027 SHALL, while rst=0 at an edge, empty the FIFO, clear age counters, set the FSM to IDLE, clear the write-beat counter, and drive bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0, bmem_ready=0.
REQ-028 SHALL abandon any in-flight burst or write on reset with no further beats; stored line contents are not reset.
REQ-029 SHALL drive bmem_ready=1 in the first cycle after rst returns high.

Verification
REQ-030 SHALL cover: write addr 0x40 with beats 0x11..,0x22..,0x33..,0x44..; read 0x40 in cycle T -> rvalid in T+4..T+7 with those beats in order, raddr=0x40.
REQ-031 SHALL cover: 4 back-to-back reads (0x00, 0x20, 0x40, 0x60) -> ready=0 after the 4th; 16 contiguous rvalid beats in request order; ready returns 1 the cycle after the 4th beat of the first burst.
REQ-032 SHALL cover: a read of 0x40 accepted, then a write to 0x40 completing before the first beat -> returned beats equal the new data.
REQ-033 SHALL cover: addr 0x845 with IDX_W=6 -> aliases line 0x45>>5 index 2; raddr=0x840.
REQ-034 SHALL cover: rst=0 during beat 2 of a burst with 2 queued reads -> next cycle rvalid=0 and ready=0; after release ready=1 with no stale beats.
REQ-035 SHALL cover: read accepted on the same cycle the last beat dequeues (not full) -> count unchanged, and the new burst starts LATENCY cycles after its acceptance.

Source files
------------

// File: rtl/bmem_resp.sv
// Line-organised backing memory with an in-order read queue and fixed-latency 4-beat read bursts.
// Writes arrive as 4-beat bursts on the same port.
module bmem_resp #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned IDX_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid
);

    localparam int unsigned NLINES = 1 << IDX_W;
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
    localparam int unsigned AGE_W  = 4;

    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(LATENCY);
    localparam logic [AGE_W-1:0] AGE_GO   = AGE_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    state_e            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [1:0]        wbeat_q, wbeat_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       qaddr_q [QDEPTH];
    logic [31:0]       qaddr_d [QDEPTH];
    logic [AGE_W-1:0]  age_q [QDEPTH];
    logic [AGE_W-1:0]  age_d [QDEPTH];
    logic [63:0]       line_mem [NLINES][4];

    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       raddr_q, raddr_d;
    logic [63:0]       rdata_q, rdata_d;

    logic              wr_acc, rd_acc, deq, head_rdy, next_rdy;
    logic [31:0]       head_addr;
    logic [IDX_W-1:0]  ridx, widx;

    // Queue bookkeeping; head_rdy/next_rdy look one cycle ahead so the burst starts registered.
    always_comb begin : queue_ctrl
        wr_acc   = bmem_write && ((wbeat_q != 2'd0) || ready_q);
        rd_acc   = bmem_read && !bmem_write && ready_q && (wbeat_q == 2'd0);
        head_rdy = (count_q != '0) && (age_q[rd_ptr_q] >= AGE_GO);
        next_rdy = (count_q > CNT_W'(1)) && (age_q[ptr_inc(rd_ptr_q)] >= AGE_GO);
        deq      = (state_q == S_BURST) && (beat_q == 2'd3);
        wbeat_d  = wr_acc ? wbeat_q + 2'd1 : wbeat_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = rd_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q + CNT_W'(rd_acc) - CNT_W'(deq);
        qaddr_d  = qaddr_q;
        if (rd_acc) begin
            qaddr_d[wr_ptr_q] = bmem_addr;
        end
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            age_d[i] = (age_q[i] < AGE_MAX) ? age_q[i] + AGE_W'(1) : age_q[i];
            if (rd_acc && (wr_ptr_q == PTR_W'(i))) begin
                age_d[i] = AGE_W'(1);
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE, S_WAIT: begin
                if (head_rdy) begin
                    state_d = S_BURST;
                    beat_d  = 2'd0;
                end else if (count_q != '0) begin
                    state_d = S_WAIT;
                end
            end
            S_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    if (next_rdy) begin
                        state_d = S_BURST;
                    end else if ((count_q > CNT_W'(1)) || rd_acc) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = 2'd0;
            end
        endcase
    end

    // Beat data is taken from the array, with a same-edge write beat forwarded in.
    always_comb begin : fsm_out
        head_addr = qaddr_q[rd_ptr_d];
        ridx      = head_addr[5 +: IDX_W];
        widx      = bmem_addr[5 +: IDX_W];
        ready_d   = (wbeat_d != 2'd0) || (count_d != CNT_FULL);
        rvalid_d  = (state_d == S_BURST);
        raddr_d   = '0;
        rdata_d   = '0;
        if (rvalid_d) begin
            raddr_d = head_addr & 32'hFFFF_FFE0;
            rdata_d = line_mem[ridx][beat_d];
            if (wr_acc && (widx == ridx) && (wbeat_q == beat_d)) begin
                rdata_d = bmem_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin : state_reg
        if (!rst) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clk) begin : ctrl_reg
        if (!rst) begin
            wbeat_q  <= 2'd0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            raddr_q  <= '0;
            rdata_q  <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            wbeat_q  <= wbeat_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            raddr_q  <= raddr_d;
            rdata_q  <= rdata_d;
            age_q    <= age_d;
        end
    end

    // Queue addresses and line contents carry no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin : data_reg
        qaddr_q <= qaddr_d;
        if (rst && wr_acc) begin
            line_mem[widx][wbeat_q] <= bmem_wdata;
        end
    end

    assign bmem_ready  = ready_q;
    assign bmem_rvalid = rvalid_q;
    assign bmem_raddr  = raddr_q;
    assign bmem_rdata  = rdata_q;

endmodule

// File: tb/tb_bmem_resp.sv
// Self-checking bench for bmem_resp: a schedule-based model (burst start = max(accept+LATENCY, prev end+1))
// is compared every cycle, plus directed scenarios pinned with literal expectations.
module tb_bmem_resp;

    localparam int unsigned LAT  = 4;
    localparam int unsigned QD   = 4;
    localparam int unsigned IDXW = 6;
    localparam int unsigned NL   = 1 << IDXW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    always #5 clk = ~clk;

    bmem_resp #(.LATENCY(LAT), .QDEPTH(QD), .IDX_W(IDXW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state: line contents, pending bursts with their scheduled start cycle.
    logic [63:0] mem_m [NL][4];
    logic [31:0] q_addr [$];
    int          q_start [$];
    int          last_end  = -100;
    int          wbeat_m   = 0;
    bit          in_reset_m = 1'b1;

    logic        s_rvalid, s_ready;
    logic [31:0] s_raddr;
    logic [63:0] s_rdata;
    bit          acc_rd, acc_wr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare at negedge against the model, then apply the edge to the model.
    task automatic cycle();
        logic [31:0]     ea, ta;
        logic [63:0]     ed;
        logic            ev, er;
        logic [IDXW-1:0] idx;
        int              beat, st;
        @(negedge clk);
        while (q_start.size() > 0 && q_start[0] + 3 < cyc) begin
            void'(q_start.pop_front());
            void'(q_addr.pop_front());
        end
        ev = 1'b0; ea = '0; ed = '0;
        er = !in_reset_m && (wbeat_m != 0 || q_start.size() < QD);
        if (q_start.size() > 0 && q_start[0] <= cyc) begin
            ev   = 1'b1;
            beat = cyc - q_start[0];
            ta   = q_addr[0];
            idx  = ta[5 +: IDXW];
            ea   = ta & 32'hFFFF_FFE0;
            ed   = mem_m[idx][beat];
        end
        s_rvalid = bmem_rvalid; s_ready = bmem_ready; s_raddr = bmem_raddr; s_rdata = bmem_rdata;
        check("rvalid", 64'(s_rvalid), 64'(ev));
        check("ready", 64'(s_ready), 64'(er));
        check("raddr", 64'(s_raddr), 64'(ea));
        check("rdata", s_rdata, ed);
        acc_wr = bmem_write && (wbeat_m != 0 || er);
        acc_rd = bmem_read && !bmem_write && er && (wbeat_m == 0);
        @(posedge clk);
        if (!rst) begin
            q_addr.delete(); q_start.delete();
            wbeat_m = 0; in_reset_m = 1'b1; last_end = -100;
            acc_wr = 1'b0; acc_rd = 1'b0;
        end else begin
            in_reset_m = 1'b0;
            if (acc_wr) begin
                ta  = bmem_addr;
                idx = ta[5 +: IDXW];
                mem_m[idx][wbeat_m] = bmem_wdata;
                wbeat_m = (wbeat_m + 1) % 4;
            end
            if (acc_rd) begin
                st = (cyc + int'(LAT) > last_end + 1) ? cyc + int'(LAT) : last_end + 1;
                q_addr.push_back(bmem_addr);
                q_start.push_back(st);
                last_end = st + 3;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        bmem_read = 1'b0; bmem_write = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3);
        logic [63:0] d [4];
        int g;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        bmem_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bmem_write = 1'b1; bmem_addr = a; bmem_wdata = d[k];
            g = 0;
            do begin cycle(); g++; end while (!acc_wr && g < 64);
            if (!acc_wr) check("wr_accept_timeout", 64'(acc_wr), 64'd1);
        end
        bmem_write = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a);
        int g;
        bmem_write = 1'b0; bmem_read = 1'b1; bmem_addr = a;
        g = 0;
        do begin cycle(); g++; end while (!acc_rd && g < 64);
        if (!acc_rd) check("rd_accept_timeout", 64'(acc_rd), 64'd1);
        bmem_read = 1'b0;
    endtask

    initial begin
        logic [63:0] lit [4];
        logic [31:0] waddr;
        int nv, r;
        rst = 1'b0; bmem_addr = '0; bmem_read = 1'b0; bmem_write = 1'b0; bmem_wdata = '0;
        @(posedge clk); #1; cyc = 1;

        // Reset behaviour and release.
        idle(3);
        check("rst_ready", 64'(s_ready), 64'd0);
        check("rst_rvalid", 64'(s_rvalid), 64'd0);
        rst = 1'b1;
        idle(1);
        idle(1);
        check("ready_after_rst", 64'(s_ready), 64'd1);

        // Give every line known contents.
        for (int i = 0; i < int'(NL); i++)
            do_write(32'(i) << 5, {$urandom, $urandom}, {$urandom, $urandom},
                     {$urandom, $urandom}, {$urandom, $urandom});
        idle(4);

        // Basic write then read of line 0x40.
        lit[0] = 64'h1111_1111_1111_1111; lit[1] = 64'h2222_2222_2222_2222;
        lit[2] = 64'h3333_3333_3333_3333; lit[3] = 64'h4444_4444_4444_4444;
        do_write(32'h40, lit[0], lit[1], lit[2], lit[3]);
        do_read(32'h40);
        idle(3);
        check("basic_early", 64'(s_rvalid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("basic_rvalid", 64'(s_rvalid), 64'd1);
            check("basic_rdata", s_rdata, lit[k]);
            check("basic_raddr", 64'(s_raddr), 64'h40);
        end
        idle(1);
        check("basic_after", 64'(s_rvalid), 64'd0);
        idle(4);

        // Four back-to-back reads fill the queue.
        for (int k = 0; k < 4; k++) begin
            bmem_read = 1'b1; bmem_addr = 32'(k) << 5;
            cycle();
            check("fill_acc", 64'(acc_rd), 64'd1);
        end
        bmem_read = 1'b0;
        nv = 0;
        for (int c = 4; c <= 20; c++) begin
            cycle();
            if (c <= 19) nv += int'(s_rvalid);
            if (c == 4) begin
                check("fill_full", 64'(s_ready), 64'd0);
                check("fill_raddr0", 64'(s_raddr), 64'h00);
            end
            if (c == 7) check("fill_last_beat_ready", 64'(s_ready), 64'd0);
            if (c == 8) begin
                check("fill_ready_rise", 64'(s_ready), 64'd1);
                check("fill_raddr1", 64'(s_raddr), 64'h20);
            end
            if (c == 12) check("fill_raddr2", 64'(s_raddr), 64'h40);
            if (c == 16) check("fill_raddr3", 64'(s_raddr), 64'h60);
            if (c == 20) check("fill_done", 64'(s_rvalid), 64'd0);
        end
        check("fill_beats", 64'(nv), 64'd16);
        idle(4);

        // Write to the same line lands before each beat is returned.
        lit[0] = 64'hAAAA_AAAA_AAAA_AAAA; lit[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        lit[2] = 64'hCCCC_CCCC_CCCC_CCCC; lit[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        do_read(32'h40);
        do_write(32'h40, lit[0], lit[1], lit[2], lit[3]);
        check("raw_beat0", s_rdata, lit[0]);
        for (int k = 1; k < 4; k++) begin
            idle(1);
            check("raw_beat", s_rdata, lit[k]);
        end
        idle(4);

        // Address aliasing: 0x845 maps to line index 2.
        do_write(32'h40, 64'h0123_4567_89AB_CDEF, 64'h1, 64'h2, 64'h3);
        do_read(32'h845);
        idle(4);
        check("alias_raddr", 64'(s_raddr), 64'h840);
        check("alias_rdata", s_rdata, 64'h0123_4567_89AB_CDEF);
        idle(4);

        // Reset during beat 2 with another read queued.
        do_read(32'h00);
        do_read(32'h20);
        idle(4);
        rst = 1'b0;
        idle(1);
        check("rstmid_beat2", 64'(s_rvalid), 64'd1);
        rst = 1'b1;
        idle(1);
        check("rstmid_rvalid", 64'(s_rvalid), 64'd0);
        check("rstmid_ready", 64'(s_ready), 64'd0);
        idle(1);
        check("rstmid_ready_up", 64'(s_ready), 64'd1);
        nv = 0;
        for (int i = 0; i < 10; i++) begin idle(1); nv += int'(s_rvalid); end
        check("rstmid_no_stale", 64'(nv), 64'd0);

        // Enqueue on the same cycle as the last beat's dequeue.
        do_read(32'h60);
        idle(6);
        bmem_read = 1'b1; bmem_addr = 32'hA0;
        cycle();
        bmem_read = 1'b0;
        check("deqenq_last", 64'(s_rvalid), 64'd1);
        check("deqenq_acc", 64'(acc_rd), 64'd1);
        idle(1);
        check("deqenq_ready", 64'(s_ready), 64'd1);
        check("deqenq_gap", 64'(s_rvalid), 64'd0);
        idle(2);
        check("deqenq_gap2", 64'(s_rvalid), 64'd0);
        idle(1);
        check("deqenq_start", 64'(s_rvalid), 64'd1);
        check("deqenq_raddr", 64'(s_raddr), 64'hA0);
        idle(4);

        // Randomized traffic against the model.
        waddr = '0;
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 199));
            rst = (r == 199) ? 1'b0 : 1'b1;
            if (wbeat_m != 0) begin
                bmem_write = 1'b1; bmem_addr = waddr;
                bmem_wdata = {$urandom, $urandom};
                bmem_read = 1'($urandom_range(0, 1));
            end else if (r < 20) begin
                waddr = $urandom;
                bmem_write = 1'b1; bmem_read = 1'b0; bmem_addr = waddr;
                bmem_wdata = {$urandom, $urandom};
            end else if (r < 100) begin
                bmem_write = 1'b0; bmem_read = 1'b1; bmem_addr = $urandom;
            end else begin
                bmem_write = 1'b0; bmem_read = 1'b0; bmem_addr = $urandom;
            end
            cycle();
        end
        rst = 1'b1;
        idle(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
